// File: rtl/i2c_codec_init_if.sv
// Handshake bus between the codec init sequencer and I2C_Interface.
// The sequencer drives DATA and ACTIVATE; the I2C engine answers with END and ACK.
interface i2c_codec_init_if;
    logic [23:0] DATA;
    logic        ACTIVATE;
    logic        END;
    logic        ACK;

    modport master (
        output DATA,
        output ACTIVATE,
        input  END,
        input  ACK
    );

    modport slave (
        input  DATA,
        input  ACTIVATE,
        output END,
        output ACK
    );
endinterface

// File: rtl/i2c_codec_init.sv
// WM8731 power-up sequencer: waits for codec power-up, then writes a fixed
// 10-entry register table through I2C_Interface, retrying failed entries.
module i2c_codec_init #(
    parameter logic [7:0]  DEV_ADDR    = 8'h34,
    parameter int unsigned PWR_WAIT    = 1000,
    parameter int unsigned GAP_CYCLES  = 4,
    parameter int unsigned END_TIMEOUT = 4096,
    parameter int unsigned RETRY_MAX   = 3
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     START,
    i2c_codec_init_if.master         bus,
    output logic                     INIT_DONE,
    output logic                     INIT_FAIL,
    output logic [3:0]               REG_IDX,
    output logic [1:0]               RETRY_CNT
);

    // One down-counter serves power-up wait, END timeout and inter-transaction gap.
    localparam int unsigned CMAX = (PWR_WAIT > END_TIMEOUT)
        ? ((PWR_WAIT > GAP_CYCLES) ? PWR_WAIT : GAP_CYCLES)
        : ((END_TIMEOUT > GAP_CYCLES) ? END_TIMEOUT : GAP_CYCLES);
    localparam int unsigned CW = $clog2(CMAX + 1);

    localparam logic [CW-1:0] PWR_LOAD  = CW'(PWR_WAIT - 1);
    localparam logic [CW-1:0] TMO_LOAD  = CW'(END_TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [1:0]    RETRY_LIM = 2'(RETRY_MAX);
    localparam logic [3:0]    LAST_IDX  = 4'd9;

    typedef enum logic [3:0] {
        IDLE,
        WAIT_PWR,
        LOAD,
        SEND,
        WAIT_END,
        CHECK,
        GAP,
        DONE,
        FAIL
    } state_t;

    function automatic logic [15:0] rom_word(input logic [3:0] idx);
        case (idx)
            4'd0:    rom_word = 16'h1E00;
            4'd1:    rom_word = 16'h0017;
            4'd2:    rom_word = 16'h0217;
            4'd3:    rom_word = 16'h0479;
            4'd4:    rom_word = 16'h0679;
            4'd5:    rom_word = 16'h0812;
            4'd6:    rom_word = 16'h0A06;
            4'd7:    rom_word = 16'h0C00;
            4'd8:    rom_word = 16'h0E42;
            4'd9:    rom_word = 16'h1201;
            default: rom_word = 16'h0000;
        endcase
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [23:0]   data_q, data_d;
    logic          act_q, act_d;
    logic          ack_q, ack_d;
    logic          init_done_q, init_done_d;
    logic          init_fail_q, init_fail_d;
    logic [3:0]    reg_idx_q, reg_idx_d;
    logic [1:0]    retry_cnt_q, retry_cnt_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        act_d       = act_q;
        ack_d       = ack_q;
        init_done_d = init_done_q;
        init_fail_d = init_fail_q;
        reg_idx_d   = reg_idx_q;
        retry_cnt_d = retry_cnt_q;

        case (state_q)
            IDLE, DONE, FAIL: begin
                if (START) begin
                    state_d     = WAIT_PWR;
                    init_done_d = 1'b0;
                    init_fail_d = 1'b0;
                    reg_idx_d   = '0;
                    retry_cnt_d = '0;
                    cnt_d       = PWR_LOAD;
                end
            end
            WAIT_PWR: begin
                if (cnt_q == '0) state_d = LOAD;
                else             cnt_d   = cnt_q - CNT_ONE;
            end
            LOAD: begin
                data_d  = {DEV_ADDR, rom_word(reg_idx_q)};
                state_d = SEND;
            end
            SEND: begin
                act_d   = 1'b1;
                cnt_d   = TMO_LOAD;
                state_d = WAIT_END;
            end
            WAIT_END: begin
                // END wins over a timeout landing in the same cycle.
                if (bus.END) begin
                    ack_d   = bus.ACK;
                    act_d   = 1'b0;
                    state_d = CHECK;
                end else if (cnt_q == '0) begin
                    ack_d   = 1'b1;
                    act_d   = 1'b0;
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            CHECK: begin
                if (!ack_q) begin
                    retry_cnt_d = '0;
                    if (reg_idx_q == LAST_IDX) begin
                        state_d     = DONE;
                        init_done_d = 1'b1;
                    end else begin
                        reg_idx_d = reg_idx_q + 4'd1;
                        cnt_d     = GAP_LOAD;
                        state_d   = GAP;
                    end
                end else if (retry_cnt_q < RETRY_LIM) begin
                    retry_cnt_d = retry_cnt_q + 2'd1;
                    cnt_d       = GAP_LOAD;
                    state_d     = GAP;
                end else begin
                    state_d     = FAIL;
                    init_fail_d = 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == '0) state_d = LOAD;
                else             cnt_d   = cnt_q - CNT_ONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            data_q      <= '0;
            act_q       <= 1'b0;
            ack_q       <= 1'b0;
            init_done_q <= 1'b0;
            init_fail_q <= 1'b0;
            reg_idx_q   <= '0;
            retry_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            act_q       <= act_d;
            ack_q       <= ack_d;
            init_done_q <= init_done_d;
            init_fail_q <= init_fail_d;
            reg_idx_q   <= reg_idx_d;
            retry_cnt_q <= retry_cnt_d;
        end
    end

    assign bus.DATA     = data_q;
    assign bus.ACTIVATE = act_q;
    assign INIT_DONE    = init_done_q;
    assign INIT_FAIL    = init_fail_q;
    assign REG_IDX      = reg_idx_q;
    assign RETRY_CNT    = retry_cnt_q;

endmodule

// File: tb/tb_i2c_codec_init.sv
// Directed bench for i2c_codec_init with a behavioural I2C_Interface responder.
module tb_i2c_codec_init;

    localparam int unsigned PWR_WAIT_TB = 10;
    localparam int unsigned GAP_TB      = 4;
    localparam int unsigned TMO_TB      = 64;
    localparam int unsigned LAT_EXP     = 13;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       init_done;
    logic       init_fail;
    logic [3:0] reg_idx;
    logic [1:0] retry_cnt;

    i2c_codec_init_if bus ();

    i2c_codec_init #(
        .DEV_ADDR   (8'h34),
        .PWR_WAIT   (PWR_WAIT_TB),
        .GAP_CYCLES (GAP_TB),
        .END_TIMEOUT(TMO_TB),
        .RETRY_MAX  (3)
    ) dut (
        .CLK      (clk),
        .RESET    (rst),
        .START    (start),
        .bus      (bus),
        .INIT_DONE(init_done),
        .INIT_FAIL(init_fail),
        .REG_IDX  (reg_idx),
        .RETRY_CNT(retry_cnt)
    );

    always #5 clk = ~clk;

    logic [23:0] exp_tbl [10] = '{24'h341E00, 24'h340017, 24'h340217, 24'h340479, 24'h340679,
                                  24'h340812, 24'h340A06, 24'h340C00, 24'h340E42, 24'h341201};

    int n_cmp = 0;
    int n_bad = 0;

    // Responder: 0 = always ack, 1 = one NACK on 0x0479, 2 = always NACK 0x0812, 3 = never END
    int mode = 0;
    int m_cnt = 0;
    bit nacked3 = 1'b0;

    always @(negedge clk) begin
        if (bus.ACTIVATE) m_cnt++;
        else              m_cnt = 0;
        bus.END = 1'b0;
        bus.ACK = 1'b0;
        if (m_cnt == 20 && mode != 3) begin
            bus.END = 1'b1;
            if (mode == 1 && bus.DATA == 24'h340479 && !nacked3) begin
                bus.ACK = 1'b1;
                nacked3 = 1'b1;
            end
            if (mode == 2 && bus.DATA == 24'h340812) bus.ACK = 1'b1;
        end
    end

    // Bus monitor: words and RETRY_CNT at each ACTIVATE rise, high/low run lengths, DATA stability.
    logic [23:0] txq [$];
    logic [1:0]  rq [$];
    int          hiq [$];
    int          hi_run = 0;
    int          lo_run = 0;
    int          min_gap = 1000;
    int          unstable = 0;
    bit          in_low = 1'b0;
    logic        act_prev = 1'b0;
    logic [23:0] data_prev = '0;

    always @(negedge clk) begin
        if (bus.ACTIVATE === 1'b1 && act_prev === 1'b0) begin
            txq.push_back(bus.DATA);
            rq.push_back(retry_cnt);
            if (bus.DATA !== data_prev) unstable++;
            if (in_low && lo_run < min_gap) min_gap = lo_run;
        end
        if (bus.ACTIVATE === 1'b1 && act_prev === 1'b1 && bus.DATA !== data_prev) unstable++;
        if (bus.ACTIVATE === 1'b0 && act_prev === 1'b1) begin
            hiq.push_back(hi_run);
            in_low = 1'b1;
            lo_run = 0;
        end
        if (bus.ACTIVATE === 1'b1) hi_run = (act_prev === 1'b1) ? hi_run + 1 : 1;
        else                       hi_run = 0;
        if (bus.ACTIVATE !== 1'b1) lo_run++;
        act_prev  = bus.ACTIVATE;
        data_prev = bus.DATA;
    end

    task automatic clear_mon();
        txq.delete();
        rq.delete();
        hiq.delete();
        min_gap  = 1000;
        unstable = 0;
        in_low   = 1'b0;
    endtask

    task automatic do_start(output int lat);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 1;
        while (bus.ACTIVATE !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic wait_flags(output bit timed_out);
        int n = 0;
        while (!(init_done === 1'b1 || init_fail === 1'b1) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        timed_out = (n >= 3000);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bus.DATA !== 24'h0)   begin n_bad++; $display("FAIL reset_data got %h want 000000", bus.DATA); end
        n_cmp++; if (bus.ACTIVATE !== 1'b0) begin n_bad++; $display("FAIL reset_activate got %b want 0", bus.ACTIVATE); end
        n_cmp++; if (init_done !== 1'b0)    begin n_bad++; $display("FAIL reset_done got %b want 0", init_done); end
        n_cmp++; if (init_fail !== 1'b0)    begin n_bad++; $display("FAIL reset_fail got %b want 0", init_fail); end
        n_cmp++; if (reg_idx !== 4'd0)      begin n_bad++; $display("FAIL reset_idx got %0d want 0", reg_idx); end
        n_cmp++; if (retry_cnt !== 2'd0)    begin n_bad++; $display("FAIL reset_retry got %0d want 0", retry_cnt); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_normal();
        int lat;
        bit to;
        mode = 0;
        clear_mon();
        do_start(lat);
        n_cmp++; if (lat != LAT_EXP) begin n_bad++; $display("FAIL normal_latency got %0d want %0d", lat, LAT_EXP); end
        wait_flags(to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL normal_timeout got expired want flag"); end
        n_cmp++; if (txq.size() != 10) begin n_bad++; $display("FAIL normal_count got %0d want 10", txq.size()); end
        for (int i = 0; i < 10 && i < txq.size(); i++) begin
            n_cmp++;
            if (txq[i] !== exp_tbl[i]) begin n_bad++; $display("FAIL normal_word%0d got %h want %h", i, txq[i], exp_tbl[i]); end
        end
        n_cmp++; if (hiq.size() < 1 || hiq[0] != 20) begin n_bad++; $display("FAIL normal_hi_run got %0d want 20", (hiq.size() > 0) ? hiq[0] : -1); end
        @(negedge clk);
        n_cmp++; if (init_done !== 1'b1) begin n_bad++; $display("FAIL normal_done got %b want 1", init_done); end
        n_cmp++; if (init_fail !== 1'b0) begin n_bad++; $display("FAIL normal_fail got %b want 0", init_fail); end
        n_cmp++; if (reg_idx !== 4'd9)   begin n_bad++; $display("FAIL normal_idx got %0d want 9", reg_idx); end
        n_cmp++; if (retry_cnt !== 2'd0) begin n_bad++; $display("FAIL normal_retry got %0d want 0", retry_cnt); end
        n_cmp++; if (bus.ACTIVATE !== 1'b0) begin n_bad++; $display("FAIL normal_act got %b want 0", bus.ACTIVATE); end
        n_cmp++; if (bus.DATA !== 24'h341201) begin n_bad++; $display("FAIL normal_last_data got %h want 341201", bus.DATA); end
        n_cmp++; if (min_gap < GAP_TB) begin n_bad++; $display("FAIL normal_gap got %0d want >=%0d", min_gap, GAP_TB); end
        n_cmp++; if (unstable != 0) begin n_bad++; $display("FAIL normal_data_stable got %0d changes want 0", unstable); end
    endtask

    task automatic test_retry_once();
        int unsigned map [11] = '{0, 1, 2, 3, 3, 4, 5, 6, 7, 8, 9};
        int lat;
        bit to;
        mode = 1;
        nacked3 = 1'b0;
        clear_mon();
        do_start(lat);
        wait_flags(to);
        @(negedge clk);
        n_cmp++; if (to) begin n_bad++; $display("FAIL retry_timeout got expired want flag"); end
        n_cmp++; if (txq.size() != 11) begin n_bad++; $display("FAIL retry_count got %0d want 11", txq.size()); end
        for (int i = 0; i < 11 && i < txq.size(); i++) begin
            n_cmp++;
            if (txq[i] !== exp_tbl[map[i]]) begin n_bad++; $display("FAIL retry_word%0d got %h want %h", i, txq[i], exp_tbl[map[i]]); end
        end
        if (rq.size() >= 6) begin
            n_cmp++; if (rq[3] !== 2'd0) begin n_bad++; $display("FAIL retry_cnt_first got %0d want 0", rq[3]); end
            n_cmp++; if (rq[4] !== 2'd1) begin n_bad++; $display("FAIL retry_cnt_second got %0d want 1", rq[4]); end
            n_cmp++; if (rq[5] !== 2'd0) begin n_bad++; $display("FAIL retry_cnt_next got %0d want 0", rq[5]); end
        end
        n_cmp++; if (init_done !== 1'b1) begin n_bad++; $display("FAIL retry_done got %b want 1", init_done); end
        n_cmp++; if (init_fail !== 1'b0) begin n_bad++; $display("FAIL retry_fail got %b want 0", init_fail); end
    endtask

    task automatic test_nack_fail();
        int unsigned map [9] = '{0, 1, 2, 3, 4, 5, 5, 5, 5};
        int lat;
        bit to;
        mode = 2;
        clear_mon();
        do_start(lat);
        n_cmp++; if (init_done !== 1'b0) begin n_bad++; $display("FAIL fail_done_cleared got %b want 0", init_done); end
        wait_flags(to);
        repeat (10) @(negedge clk);
        n_cmp++; if (to) begin n_bad++; $display("FAIL fail_timeout got expired want flag"); end
        n_cmp++; if (txq.size() != 9) begin n_bad++; $display("FAIL fail_count got %0d want 9", txq.size()); end
        for (int i = 0; i < 9 && i < txq.size(); i++) begin
            n_cmp++;
            if (txq[i] !== exp_tbl[map[i]]) begin n_bad++; $display("FAIL fail_word%0d got %h want %h", i, txq[i], exp_tbl[map[i]]); end
        end
        n_cmp++; if (init_fail !== 1'b1) begin n_bad++; $display("FAIL fail_flag got %b want 1", init_fail); end
        n_cmp++; if (init_done !== 1'b0) begin n_bad++; $display("FAIL fail_done got %b want 0", init_done); end
        n_cmp++; if (reg_idx !== 4'd5)   begin n_bad++; $display("FAIL fail_idx got %0d want 5", reg_idx); end
        n_cmp++; if (retry_cnt !== 2'd3) begin n_bad++; $display("FAIL fail_retry got %0d want 3", retry_cnt); end
        n_cmp++; if (bus.ACTIVATE !== 1'b0) begin n_bad++; $display("FAIL fail_act got %b want 0", bus.ACTIVATE); end
    endtask

    task automatic test_end_timeout();
        int lat;
        bit to;
        mode = 3;
        clear_mon();
        do_start(lat);
        n_cmp++; if (lat != LAT_EXP) begin n_bad++; $display("FAIL tmo_latency got %0d want %0d", lat, LAT_EXP); end
        wait_flags(to);
        @(negedge clk);
        n_cmp++; if (to) begin n_bad++; $display("FAIL tmo_wait got expired want flag"); end
        n_cmp++; if (txq.size() != 4) begin n_bad++; $display("FAIL tmo_count got %0d want 4", txq.size()); end
        for (int i = 0; i < txq.size() && i < 4; i++) begin
            n_cmp++;
            if (txq[i] !== 24'h341E00) begin n_bad++; $display("FAIL tmo_word%0d got %h want 341e00", i, txq[i]); end
        end
        for (int i = 0; i < hiq.size() && i < 4; i++) begin
            n_cmp++;
            if (hiq[i] != TMO_TB) begin n_bad++; $display("FAIL tmo_hi_run%0d got %0d want %0d", i, hiq[i], TMO_TB); end
        end
        n_cmp++; if (init_fail !== 1'b1) begin n_bad++; $display("FAIL tmo_fail got %b want 1", init_fail); end
        n_cmp++; if (reg_idx !== 4'd0)   begin n_bad++; $display("FAIL tmo_idx got %0d want 0", reg_idx); end
        n_cmp++; if (retry_cnt !== 2'd3) begin n_bad++; $display("FAIL tmo_retry got %0d want 3", retry_cnt); end
    endtask

    task automatic test_reset_mid();
        int lat;
        int n;
        bit to;
        mode = 0;
        clear_mon();
        do_start(lat);
        n = 0;
        while (!(bus.ACTIVATE === 1'b1 && bus.DATA === 24'h340679) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        n_cmp++; if (n >= 2000) begin n_bad++; $display("FAIL midrst_reach got expired want index 4 active"); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (bus.ACTIVATE !== 1'b0) begin n_bad++; $display("FAIL midrst_act got %b want 0", bus.ACTIVATE); end
        n_cmp++; if (bus.DATA !== 24'h0)    begin n_bad++; $display("FAIL midrst_data got %h want 000000", bus.DATA); end
        n_cmp++; if (reg_idx !== 4'd0)      begin n_bad++; $display("FAIL midrst_idx got %0d want 0", reg_idx); end
        n_cmp++; if (init_done !== 1'b0 || init_fail !== 1'b0 || retry_cnt !== 2'd0) begin
            n_bad++; $display("FAIL midrst_flags got done=%b fail=%b retry=%0d want 0 0 0", init_done, init_fail, retry_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        n_cmp++; if (bus.ACTIVATE !== 1'b0) begin n_bad++; $display("FAIL midrst_idle got %b want 0", bus.ACTIVATE); end
        clear_mon();
        do_start(lat);
        n_cmp++; if (lat != LAT_EXP) begin n_bad++; $display("FAIL midrst_latency got %0d want %0d", lat, LAT_EXP); end
        wait_flags(to);
        @(negedge clk);
        n_cmp++; if (txq.size() < 1 || txq[0] !== 24'h341E00) begin
            n_bad++; $display("FAIL midrst_first got %h want 341e00", (txq.size() > 0) ? txq[0] : 24'h0);
        end
        n_cmp++; if (init_done !== 1'b1 || txq.size() != 10) begin
            n_bad++; $display("FAIL midrst_rerun got done=%b txns=%0d want 1 10", init_done, txq.size());
        end
    endtask

    task automatic test_start_ignored();
        int lat;
        int n;
        bit to;
        mode = 0;
        clear_mon();
        do_start(lat);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (bus.ACTIVATE === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_flags(to);
        @(negedge clk);
        n_cmp++; if (to) begin n_bad++; $display("FAIL ign_wait got expired want flag"); end
        n_cmp++; if (txq.size() != 10) begin n_bad++; $display("FAIL ign_count got %0d want 10", txq.size()); end
        for (int i = 0; i < 10 && i < txq.size(); i++) begin
            n_cmp++;
            if (txq[i] !== exp_tbl[i]) begin n_bad++; $display("FAIL ign_word%0d got %h want %h", i, txq[i], exp_tbl[i]); end
        end
        n_cmp++; if (init_done !== 1'b1) begin n_bad++; $display("FAIL ign_done got %b want 1", init_done); end
        n_cmp++; if (min_gap < GAP_TB) begin n_bad++; $display("FAIL ign_gap got %0d want >=%0d", min_gap, GAP_TB); end
        n_cmp++; if (unstable != 0) begin n_bad++; $display("FAIL ign_data_stable got %0d changes want 0", unstable); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_normal();
        test_retry_once();
        test_nack_fail();
        test_end_timeout();
        test_reset_mid();
        test_start_ignored();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
